// File: rtl/turn_scheduler_if.sv
// Handshake bundle between the dice source, the turn scheduler and the per-player movement controllers.
interface turn_scheduler_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
);
  logic                   roll_valid;
  logic [2:0]             roll_value;
  logic                   roll_ready;
  logic                   roll_error;
  logic                   new_game;
  logic [NUM_PLAYERS-1:0] move_start;
  logic [9:0]             target_x;
  logic [NUM_PLAYERS-1:0] move_done;
  logic [PW-1:0]          active_player;
  logic                   timeout_err;
  logic                   game_over;
  logic [PW-1:0]          winner;

  modport master (
    output roll_valid, roll_value, new_game, move_done,
    input  roll_ready, roll_error, move_start, target_x, active_player,
           timeout_err, game_over, winner
  );

  modport slave (
    input  roll_valid, roll_value, new_game, move_done,
    output roll_ready, roll_error, move_start, target_x, active_player,
           timeout_err, game_over, winner
  );
endinterface

// File: rtl/turn_scheduler.sv
// Turn sequencer: turns a roll into a clamped target, launches the active player's move,
// waits for done (or timeout), commits the position, rotates the turn and detects the winner.
module turn_scheduler #(
  parameter int NUM_PLAYERS    = 2,
  parameter int NUM_TILES      = 11,
  parameter int MAX_ROLL       = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic             clk,
  input logic             reset,
  turn_scheduler_if.slave bus
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int TW = $clog2(NUM_TILES);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] FLAG = TW'(NUM_TILES - 1);
  localparam logic [2:0]    MAXR = 3'(MAX_ROLL);

  typedef enum logic [1:0] {WAIT_ROLL, LAUNCH, MOVING, GAME_OVER} state_t;

  state_t                 state, state_nx;
  logic [TW-1:0]          pos [NUM_PLAYERS];
  logic [TW-1:0]          target;
  logic [PW-1:0]          active;
  logic [PW-1:0]          win;
  logic [CW-1:0]          cnt;
  logic [NUM_PLAYERS-1:0] start_q;
  logic                   err_q;
  logic                   tmo_q;

  logic                   accept;
  logic                   legal;
  logic                   done_act;
  logic                   tmo_hit;
  logic                   turn_end;
  logic                   restart;
  logic [TW+2:0]          sum;
  logic [TW-1:0]          clamped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_ROLL;
    else       state <= state_nx;
  end

  always_comb begin
    accept   = 1'b0;
    legal    = 1'b0;
    done_act = 1'b0;
    tmo_hit  = 1'b0;
    turn_end = 1'b0;
    restart  = 1'b0;
    state_nx = state;
    sum      = (TW+3)'(pos[active]) + (TW+3)'(bus.roll_value);
    clamped  = (sum >= (TW+3)'(NUM_TILES - 1)) ? FLAG : sum[TW-1:0];

    accept   = (state == WAIT_ROLL) && bus.roll_valid;
    legal    = (bus.roll_value != 3'd0) && (bus.roll_value <= MAXR);
    done_act = bus.move_done[active];
    tmo_hit  = (state == MOVING) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    // Done is honoured already in LAUNCH for zero-latency controllers.
    turn_end = ((state == LAUNCH) || (state == MOVING)) && (done_act || tmo_hit);
    restart  = (state == GAME_OVER) && bus.new_game;

    case (state)
      WAIT_ROLL: if (accept && legal) state_nx = LAUNCH;
      LAUNCH,
      MOVING: begin
        if (turn_end)             state_nx = (target == FLAG) ? GAME_OVER : WAIT_ROLL;
        else if (state == LAUNCH) state_nx = MOVING;
      end
      GAME_OVER: if (restart) state_nx = WAIT_ROLL;
      default:   state_nx = WAIT_ROLL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) pos[i] <= '0;
      target  <= '0;
      active  <= '0;
      win     <= '0;
      cnt     <= '0;
      start_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      err_q   <= accept && !legal;
      start_q <= (accept && legal) ? (NUM_PLAYERS'(1) << active) : '0;
      // A done in the same cycle as the timeout wins, so no error pulse then.
      tmo_q   <= turn_end && !done_act;

      if (accept && legal) target <= clamped;

      if (state == LAUNCH)      cnt <= '0;
      else if (state == MOVING) cnt <= cnt + CW'(1);

      if (turn_end) begin
        pos[active] <= target;
        if (target == FLAG)                      win    <= active;
        else if (active == PW'(NUM_PLAYERS - 1)) active <= '0;
        else                                     active <= active + PW'(1);
      end

      if (restart) begin
        for (int i = 0; i < NUM_PLAYERS; i++) pos[i] <= '0;
        active <= '0;
        win    <= '0;
      end
    end
  end

  assign bus.roll_ready    = (state == WAIT_ROLL);
  assign bus.roll_error    = err_q;
  assign bus.move_start    = start_q;
  assign bus.target_x      = 10'(target);
  assign bus.active_player = active;
  assign bus.timeout_err   = tmo_q;
  assign bus.game_over     = (state == GAME_OVER);
  assign bus.winner        = win;
endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Turn sequencer for the board-game UI. It shares the single dice/roll source between `NUM_PLAYERS` per-player movement controllers. Each roll is converted into a clamped target tile and launched on the active player's controller with a one-cycle start pulse. The block then waits for that controller's completion pulse, rotates the turn and detects the winner on the flag tile. It sits between the input/dice logic and the per-player movement FSMs that feed the sprite renderer.

## Interface
- `NUM_PLAYERS`, 2: number of players/controllers, 2..4.
- `NUM_TILES`, 11: board length in tiles; tile `NUM_TILES-1` is the flag (goal) tile; max 16.
- `MAX_ROLL`, 6: largest legal roll value, 1..7.
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles spent in MOVING before a forced turn end.
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `roll_valid`, in, 1: roll offered this cycle.
- `roll_value`, in, 3: roll amount.
- `roll_ready`, out, 1: scheduler accepts a roll this cycle.
- `roll_error`, out, 1: 1-cycle pulse; an offered roll was rejected.
- `new_game`, in, 1: restart request; only honoured in GAME_OVER.
- `move_start`, out, `NUM_PLAYERS`: one-hot, 1-cycle start pulse to the addressed controller.
- `target_x`, out, 10: target tile index for the launched move.
- `move_done`, in, `NUM_PLAYERS`: per-controller turn-complete pulses.
- `active_player`, out, PW = max(1, $clog2(`NUM_PLAYERS`)): player whose turn it is.
- `timeout_err`, out, 1: 1-cycle pulse; a move was force-ended by timeout.
- `game_over`, out, 1: level; a player has reached the flag tile.
- `winner`, out, PW: winning player index; valid while `game_over` is 1.

## Operation
- **States:** WAIT_ROLL, LAUNCH, MOVING, GAME_OVER.
- **Per-player position:** `pos[i]`, width TW = $clog2(`NUM_TILES`); all reset to 0.
- **WAIT_ROLL:**
  - `roll_ready`=1.
  - Handshake: a roll is accepted when `roll_valid` && `roll_ready`.
  - Legal roll: 1..`MAX_ROLL`. On a legal roll, compute sum = `pos[active]` + `roll_value` in TW+3 bits (no overflow). Target = min(sum, `NUM_TILES`-1).
  - On a legal roll, latch the target and go to LAUNCH.
  - Illegal roll (0 or >`MAX_ROLL`): `roll_error` pulses and the state is unchanged.
- **LAUNCH:**
  - `move_start[active_player]`=1 for exactly this cycle.
  - `target_x` = latched target, zero-extended to 10 bits.
  - Go to MOVING and clear the timeout counter.
- **MOVING:**
  - Wait for `move_done[active_player]`.
  - `move_done` bits of other players are ignored.
  - `roll_valid` is ignored because `roll_ready`=0.
- **Turn end** (done received, or counter reaches `TIMEOUT_CYCLES`-1):
  - Commit `pos[active]` = target.
  - On timeout, `timeout_err` also pulses.
  - If target == `NUM_TILES`-1: go to GAME_OVER and set `winner` = `active_player`.
  - Otherwise: `active_player` = (`active_player`+1) mod `NUM_PLAYERS` and go to WAIT_ROLL.
- **GAME_OVER:**
  - `game_over`=1, `roll_ready`=0, and rolls are ignored with no `roll_error`.
  - `new_game` clears all `pos`, `active_player`, `winner` and `game_over`, then goes to WAIT_ROLL.
  - `new_game` in any other state is ignored.
- `target_x` holds its last launched value until the next LAUNCH.

## Timing
- **Reset values:**
  - State WAIT_ROLL, `roll_ready`=1.
  - `roll_error`=0, `move_start`=0, `target_x`=0, `active_player`=0, `timeout_err`=0, `game_over`=0, `winner`=0, all `pos`=0.
- **Reset is asynchronous:** outputs take their reset values immediately on assertion, including mid-MOVING. Release is sampled on the next edge.
- **Roll to launch:** roll accepted at edge N gives `move_start` high in cycle N+1 (LAUNCH), with `target_x` valid in the same cycle.
- **`roll_ready`:** drops in the cycle after acceptance.
- **Done to next turn:** `move_done` sampled at edge M gives the new `active_player` and `roll_ready`=1 (or `game_over`=1) from M+1.
- **Done in LAUNCH:** a `move_done` arriving in the LAUNCH cycle itself (zero-latency controller) is honoured as turn end.
- **Simultaneous done and timeout:** counts as a normal done; no `timeout_err`.
- **Pulse outputs:** `roll_error`, `timeout_err` and `move_start` are registered and exactly one cycle wide.

## Test plan
- **Basic turn:** reset, then roll 3 → `move_start`=01 for 1 cycle with `target_x`=3. Pulse `move_done`[0] → next cycle `active_player`=1, `roll_ready`=1.
- **Clamp and win:** player0 at tile 8 rolls 5 → `target_x`=10. Done → `game_over`=1, `winner`=0, `roll_ready`=0. Then `new_game` → all zero, WAIT_ROLL.
- **Illegal rolls:** roll 0, then roll 7 (`MAX_ROLL`=6) → two `roll_error` pulses, no `move_start`, `active_player` unchanged.
- **Timeout:** `TIMEOUT_CYCLES`=16 and no `move_done` → `timeout_err` pulses 16 cycles after LAUNCH, position committed, `active_player` advances.
- **Ignored inputs:** while MOVING, `move_done`[1] for active player 0 and `roll_valid` with roll 4 → no state change and no `roll_error`.
- **Reset mid-move:** assert `reset` while MOVING → `move_start`, `game_over` and all positions are 0 immediately. After release, `roll_ready`=1.
